// File: rtl/bw_seq_multiplier_pkg.sv
// Shared definitions for the sequential Baugh-Wooley multiplier:
// FSM state encoding, accumulator seed and counter sizing helpers.
package bw_pkg;

  // FSM states
  // state | meaning
  // IDLE  | waiting for start, product holds last result
  // RUN   | adding one partial-product row per clock
  // DONE  | one-cycle completion pulse, may accept a new start
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bw_state_e;

  // Widest operand the 64-bit seed helper can describe.
  localparam int unsigned BW_MAX_N = 32;

  // Row counter width; N >= 2 so $clog2 is never zero.
  function automatic int unsigned bw_cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Accumulator seed 2^N + 2^(2N-1): the constant correction terms of the
  // modified Baugh-Wooley scheme, folded in before the first row is added.
  // Callers truncate the result to 2N bits.
  function automatic logic [63:0] bw_init(input int unsigned n);
    logic [63:0] v;
    v = '0;
    v[n]       = 1'b1;
    v[2*n - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bw_seq_multiplier_rca_row.sv
// Ripple-carry adder row built from full_adder cells; the accumulator
// update path of the sequential multiplier. Carry-in is zero and the
// final carry-out is dropped, so the sum wraps modulo 2^W.

// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  // Sum and majority carry.
  always_comb begin
    s     = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule

module rca_row #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s
);

  // c[i] is the carry into bit i.
  logic [W-1:0] c;
  logic         carry_unused;

  assign c[0] = 1'b0;

  // W chained cells; the top cell's carry is discarded.
  for (genvar i = 0; i < W; i++) begin : g_fa
    if (i < W - 1) begin : g_mid
      full_adder u_fa (
        .a    (x[i]),
        .b    (y[i]),
        .c_in (c[i]),
        .s    (s[i]),
        .c_out(c[i+1])
      );
    end else begin : g_top
      full_adder u_fa (
        .a    (x[i]),
        .b    (y[i]),
        .c_in (c[i]),
        .s    (s[i]),
        .c_out(carry_unused)
      );
    end
  end

endmodule

// File: rtl/bw_seq_multiplier.sv
// Iterative signed NxN multiplier (modified Baugh-Wooley). One partial
// product row is added per clock into a 2N-bit accumulator through a single
// ripple-carry row; a start/busy/done handshake wraps the iteration.
module bw_seq_multiplier
  import bw_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int unsigned         CW       = bw_cnt_w(N);
  localparam int unsigned         PW       = 2 * N;
  localparam logic [63:0]         INIT_64  = bw_init(N);
  localparam logic [PW-1:0]       INIT     = INIT_64[PW-1:0];
  localparam logic [CW-1:0]       CNT_LAST = CW'(N - 1);

  bw_state_e     state;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc;
  logic [PW-1:0] product_r;
  logic [N-1:0]  row;
  logic [PW-1:0] row_sh;
  logic [PW-1:0] sum;
  logic          b_bit;
  logic          last_row;

  assign b_bit    = b_r[cnt];
  assign last_row = (cnt == CNT_LAST);

  // Partial-product row for the current counter value. Ordinary rows invert
  // the sign-position bit; the last row (sign of b) inverts all the others.
  always_comb begin
    row = '0;
    for (int j = 0; j < N; j++) begin
      row[j] = a_r[j] & b_bit;
      if (last_row) begin
        if (j != N - 1) row[j] = ~row[j];
      end else begin
        if (j == N - 1) row[j] = ~row[j];
      end
    end
  end

  // Align the row to its weight in the 2N-bit accumulator.
  always_comb begin
    row_sh = {{N{1'b0}}, row} << cnt;
  end

  rca_row #(
    .W(PW)
  ) u_row (
    .x(acc),
    .y(row_sh),
    .s(sum)
  );

  // Control FSM with operand, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      acc       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            cnt   <= '0;
            acc   <= INIT;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= sum;
          if (last_row) begin
            product_r <= sum;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs come straight from the registered state.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    product = product_r;
  end

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Self-checking bench for bw_seq_multiplier (N = 8): directed corner cases,
// handshake timing, back-to-back, mid-run start, reset abort and random
// operands compared against plain signed multiplication.
module tb_bw_seq_multiplier;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  int vectors;
  int miscompares;
  logic [2*N-1:0] last_prod;

  bw_seq_multiplier #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .product(product),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [2*N-1:0] p;
    p = $signed(x) * $signed(y);
    return p;
  endfunction

  // Issue one multiply and follow it to its done pulse. pulse_at >= 0 raises
  // start with junk operands during that busy cycle; hold_start keeps start
  // high with next_a/next_b on the bus so the done cycle re-accepts them.
  task automatic run_mul(input logic [N-1:0] x, input logic [N-1:0] y, input int pulse_at,
                         input bit hold_start, input logic [N-1:0] next_a,
                         input logic [N-1:0] next_b, input string tag);
    int n;
    int dones;
    logic [2*N-1:0] exp;
    exp   = ref_mul(x, y);
    start = 1'b1;
    a     = x;
    b     = y;
    cycle();
    check({tag, "_hold"}, product, last_prod);
    n     = 0;
    dones = 0;
    while (busy && n < 40) begin
      if (hold_start) begin
        start = 1'b1;
        a     = next_a;
        b     = next_b;
      end else if (n == pulse_at) begin
        start = 1'b1;
        a     = N'($urandom);
        b     = N'($urandom);
      end else begin
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
      end
      if (done) dones++;
      n++;
      cycle();
    end
    check({tag, "_busy_len"}, n, N);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_prod"}, product, exp);
    last_prod = exp;
    if (pulse_at >= 0) check({tag, "_early_done"}, dones, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_prod   = '0;
    rst         = 1'b1;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    cycle();
    cycle();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_prod", product, 0);
    rst = 1'b0;
    cycle();

    run_mul(8'd3, 8'd5, -1, 1'b0, '0, '0, "m3x5");
    check("m3x5_ref", product, 16'h000F);
    start = 1'b0;
    cycle();
    check("idle_done", {31'd0, done}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_prod", product, 16'h000F);

    run_mul(8'hFF, 8'h7F, -1, 1'b0, '0, '0, "m_1x127");
    check("m_1x127_ref", product, 16'hFF81);
    start = 1'b0;
    cycle();
    run_mul(8'h80, 8'h80, -1, 1'b0, '0, '0, "m_128sq");
    check("m_128sq_ref", product, 16'h4000);
    start = 1'b0;
    cycle();
    run_mul(8'h80, 8'h7F, -1, 1'b0, '0, '0, "m_128x127");
    check("m_128x127_ref", product, 16'hC080);
    start = 1'b0;
    cycle();
    run_mul(8'h00, 8'hA5, -1, 1'b0, '0, '0, "m0");
    check("m0_ref", product, 16'h0000);
    start = 1'b0;
    cycle();

    // Back-to-back: start held high; second operands accepted on the done cycle.
    run_mul(8'd2, 8'd3, -1, 1'b1, 8'hFC, 8'd6, "b2b_1");
    check("b2b_1_ref", product, 16'h0006);
    run_mul(8'hFC, 8'd6, -1, 1'b0, '0, '0, "b2b_2");
    check("b2b_2_ref", product, 16'hFFE8);
    start = 1'b0;
    cycle();
    check("b2b_end_done", {31'd0, done}, 0);

    // Start pulsed mid-run must be ignored.
    run_mul(8'd11, 8'hF7, 3, 1'b0, '0, '0, "midrun");
    start = 1'b0;
    cycle();
    check("midrun_single_done", {31'd0, done}, 0);
    check("midrun_idle", {31'd0, busy}, 0);

    // Reset during run aborts the multiply and clears product.
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd77;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_prod", product, 0);
    last_prod = '0;
    run_mul(8'd7, 8'hFD, -1, 1'b0, '0, '0, "post_rst");
    check("post_rst_ref", product, 16'hFFEB);
    start = 1'b0;
    cycle();

    // Random operands, occasionally back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] x;
      logic [N-1:0] y;
      x = N'($urandom);
      y = N'($urandom);
      run_mul(x, y, -1, 1'b0, '0, '0, "rand");
      if ($urandom_range(0, 1) == 0) begin
        start = 1'b0;
        cycle();
      end
    end
    start = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
